// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity nibble checker.
//   DATA_W        - width of the protected data word (fixed nibble)
//   CNT_W_DEFAULT - default width of the saturating error counter
//   odd_par_err() - returns 1 when {data, par} holds an even number of ones
package odd_parity_pkg;

  localparam int unsigned DATA_W        = 4;
  localparam int unsigned CNT_W_DEFAULT = 8;

  function automatic logic odd_par_err(logic [DATA_W-1:0] data, logic par);
    return ~(^data ^ par);
  endfunction

endpackage

// File: rtl/odd_parity_err_ctr.sv
// Saturating error counter for the parity link monitor.
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset, clears the count
//   inc - count one error this cycle
//   clr - clear the count; together with inc the count restarts at 1
//   cnt - current count, holds at all-ones instead of wrapping
module odd_parity_err_ctr
  import odd_parity_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      // The error that arrives with the clear is the first one of the new epoch.
      if (clr) begin
        cnt_d = CntOne;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntOne;
      end
    end else if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/odd_paritybit_check.sv
// Odd-parity checker for a nibble {a,b,c,d} with received parity bit p.
// A word is good when it and p together hold an odd number of ones.
// Build option: define ODD_PARITY_ERR_CNT_EN to implement the error counter;
// otherwise err_cnt is tied to zero and no counter flops exist.
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   a,b,c,d    - data bits 3..0 (a is the MSB)
//   p          - received odd-parity bit
//   in_valid   - the current word is logged on this edge
//   clr_sticky - clears err_sticky (and err_cnt when built in)
//   e          - combinational error flag, independent of clk/rst
//   e_q        - e captured on in_valid edges
//   err_sticky - set by any logged error, held until clr_sticky
//   err_cnt    - saturating count of logged errors (zero when not built in)
module odd_paritybit_check
  import odd_parity_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             p,
  input  logic             in_valid,
  input  logic             clr_sticky,
  output logic             e,
  output logic             e_q,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  logic [DATA_W-1:0] data;
  logic              logged_err;
  logic              e_d;
  logic              err_sticky_d;

  assign data       = {a, b, c, d};
  assign e          = odd_par_err(data, p);
  assign logged_err = in_valid & e;

  always_comb begin
    e_d = e_q;
    if (in_valid) begin
      e_d = e;
    end
  end

  // A new error outranks a simultaneous clear so no event is ever lost.
  always_comb begin
    err_sticky_d = err_sticky;
    if (logged_err) begin
      err_sticky_d = 1'b1;
    end else if (clr_sticky) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      e_q        <= e_d;
      err_sticky <= err_sticky_d;
    end
  end

`ifdef ODD_PARITY_ERR_CNT_EN
  odd_parity_err_ctr #(
    .CNT_W (CNT_W)
  ) u_err_ctr (
    .clk (clk),
    .rst (rst),
    .inc (logged_err),
    .clr (clr_sticky),
    .cnt (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_odd_paritybit_check.sv
module tb_odd_paritybit_check;

  localparam int unsigned CntW   = 4;
  localparam int unsigned CntMax = (1 << CntW) - 1;
`ifdef ODD_PARITY_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, p = 1'b0;
  logic            in_valid = 1'b0;
  logic            clr_sticky = 1'b0;
  logic            e, e_q, err_sticky;
  logic [CntW-1:0] err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  bit run         = 1'b0;

  always #5 clk = ~clk;

  odd_paritybit_check #(
    .CNT_W (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .p          (p),
    .in_valid   (in_valid),
    .clr_sticky (clr_sticky),
    .e          (e),
    .e_q        (e_q),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is bad when its ones-count is even.
  function automatic logic model_err(logic [4:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  logic        m_eq, m_sticky;
  int unsigned m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_eq     <= 1'b0;
      m_sticky <= 1'b0;
      m_cnt    <= 0;
    end else begin
      if (in_valid) m_eq <= model_err({a, b, c, d, p});
      if (in_valid && model_err({a, b, c, d, p})) begin
        m_sticky <= 1'b1;
        if (CntEn) m_cnt <= clr_sticky ? 1 : ((m_cnt >= CntMax) ? CntMax : m_cnt + 1);
      end else if (clr_sticky) begin
        m_sticky <= 1'b0;
        m_cnt    <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("cyc_e", e, model_err({a, b, c, d, p}));
      check("cyc_e_q", e_q, m_eq);
      check("cyc_sticky", err_sticky, m_sticky);
      check("cyc_cnt", err_cnt, m_cnt);
    end
  end

  task automatic set_in(logic [4:0] w, logic iv, logic clr);
    {a, b, c, d, p} = w;
    in_valid        = iv;
    clr_sticky      = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    run = 1'b1;
    tick();
    tick();
    check("rst_e_q", e_q, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_cnt", err_cnt, 0);
    rst = 1'b0;
    tick();

    // Exhaustive combinational sweep, nothing logged.
    for (int v = 0; v < 32; v++) begin
      set_in(5'(v), 1'b0, 1'b0);
      #1;
      check("sweep_e", e, ~^(5'(v)));
      if (v == 0)  check("e_00000", e, 1);
      if (v == 1)  check("e_00001", e, 0);
      if (v == 31) check("e_11111", e, 0);
      tick();
    end
    check("sweep_e_q", e_q, 0);
    check("sweep_sticky", err_sticky, 0);

    // Logging an error then a good word.
    set_in(5'b10100, 1'b1, 1'b0);
    tick();
    check("log_err_e_q", e_q, 1);
    check("log_err_sticky", err_sticky, 1);
    check("log_err_cnt", err_cnt, CntEn ? 1 : 0);
    set_in(5'b10101, 1'b1, 1'b0);
    tick();
    check("log_good_e_q", e_q, 0);
    check("log_good_sticky", err_sticky, 1);
    check("log_good_cnt", err_cnt, CntEn ? 1 : 0);

    // Erroring word not logged for 3 cycles.
    set_in(5'b11000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_e", e, 1);
      check("idle_e_q", e_q, 0);
      check("idle_sticky", err_sticky, 1);
      check("idle_cnt", err_cnt, CntEn ? 1 : 0);
    end

    // Build up to 5 errors, then reset mid-cycle.
    set_in(5'b00000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    set_in(5'b00001, 1'b0, 1'b0);
    check("pre_rst_cnt", err_cnt, CntEn ? 5 : 0);
    check("pre_rst_sticky", err_sticky, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_e_q", e_q, 0);
    check("async_rst_sticky", err_sticky, 0);
    check("async_rst_cnt", err_cnt, 0);
    rst = 1'b0;
    tick();

    // Clear concurrent with an error: set wins, count restarts at 1.
    set_in(5'b11110, 1'b1, 1'b0);
    tick();
    tick();
    check("pre_clr_cnt", err_cnt, CntEn ? 2 : 0);
    set_in(5'b11110, 1'b1, 1'b1);
    tick();
    check("clr_set_sticky", err_sticky, 1);
    check("clr_set_cnt", err_cnt, CntEn ? 1 : 0);
    set_in(5'b11110, 1'b0, 1'b1);
    tick();
    check("clr_only_sticky", err_sticky, 0);
    check("clr_only_cnt", err_cnt, 0);

    // Saturation.
    set_in(5'b01100, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (CntEn) check("sat_step_cnt", err_cnt, (i > 15) ? 15 : i);
      else       check("sat_step_cnt", err_cnt, 0);
    end
    check("sat_final_cnt", err_cnt, CntEn ? 15 : 0);
    set_in(5'b01101, 1'b0, 1'b0);
    tick();
    tick();

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
